// File: rtl/riscv_pkg.sv
// Shared definitions for the UART boot loader.
// Holds the loader state encoding and frame constants.
package riscv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CHK,
    ST_DONE,
    ST_ERROR
  } ld_state_e;

  localparam logic [7:0] MAGIC = 8'hA5;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream boot loader: parses a framed image from the UART
// and writes it into instruction memory, releasing the core when done.
module imem_loader
  import riscv_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst_n,
  output logic        done,
  output logic        err
);

  ld_state_e   state_q;
  ld_state_e   state_d;
  logic [7:0]  len_lo_q;
  logic [16:0] len_q;
  logic [16:0] wcnt_q;
  logic [1:0]  bcnt_q;
  logic [23:0] buf_q;
  logic [7:0]  chk_q;
  logic        start;
  logic        wr;
  logic [16:0] len_n;

  assign len_n = {1'b0, rx_data, len_lo_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    wr      = 1'b0;
    if (rx_valid) begin
      unique case (state_q)
        ST_IDLE, ST_ERROR: begin
          if (rx_data == MAGIC) begin
            state_d = ST_LEN_LO;
            start   = 1'b1;
          end
        end
        ST_LEN_LO: state_d = ST_LEN_HI;
        ST_LEN_HI: begin
          if (len_n > 17'(DEPTH_WORDS)) state_d = ST_ERROR;
          else if (len_n == '0)         state_d = ST_CHK;
          else                          state_d = ST_DATA;
        end
        ST_DATA: begin
          if (bcnt_q == 2'd3) begin
            wr = 1'b1;
            if (wcnt_q + 17'd1 == len_q) state_d = ST_CHK;
          end
        end
        ST_CHK: begin
          state_d = (rx_data == chk_q) ? ST_DONE : ST_ERROR;
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Status flags are registered so core_rst_n only rises on the DONE edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
      core_rst_n <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      len_lo_q   <= '0;
      len_q      <= '0;
      wcnt_q     <= '0;
      bcnt_q     <= '0;
      buf_q      <= '0;
      chk_q      <= '0;
    end else begin
      imem_we    <= wr;
      done       <= (state_d == ST_DONE);
      core_rst_n <= (state_d == ST_DONE);
      err        <= (state_d == ST_ERROR);
      if (start) begin
        chk_q  <= '0;
        wcnt_q <= '0;
        bcnt_q <= '0;
      end
      if (rx_valid && state_q == ST_LEN_LO) len_lo_q <= rx_data;
      if (rx_valid && state_q == ST_LEN_HI) len_q <= len_n;
      if (rx_valid && state_q == ST_DATA) begin
        chk_q  <= chk_q ^ rx_data;
        bcnt_q <= bcnt_q + 2'd1;
        buf_q  <= {rx_data, buf_q[23:8]};
      end
      if (wr) begin
        imem_addr  <= BASE_ADDR + {13'b0, wcnt_q, 2'b00};
        imem_wdata <= {rx_data, buf_q};
        wcnt_q     <= wcnt_q + 17'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frame parsing, checksum,
// length bounds, reset abort and rx_valid gaps.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst_n;
  logic        done;
  logic        err;

  int nvec  = 0;
  int nfail = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [7:0]  good[$];
  logic [7:0]  bad[$];

  imem_loader #(
    .DEPTH_WORDS(256),
    .BASE_ADDR(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .core_rst_n(core_rst_n),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (imem_we === 1'b1) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    if (gap > 0) idle(gap);
  endtask

  task automatic frame(input logic [7:0] f[$], input int gap);
    foreach (f[i]) send(f[i], gap);
    idle(3);
  endtask

  task automatic chk_status(input string tag, input logic [2:0] exp);
    check(tag, {29'b0, core_rst_n, done, err}, {29'b0, exp});
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_ctl"}, {28'b0, imem_we, core_rst_n, done, err}, 32'h0);
    check({tag, "_addr"}, imem_addr, 32'h0);
    check({tag, "_wdata"}, imem_wdata, 32'h0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    #1;
    chk_reset(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
  endtask

  task automatic chk_words(input string tag, input int first);
    check({tag, "_a0"}, wa[first], 32'h0000_0000);
    check({tag, "_d0"}, wd[first], 32'h0050_0093);
    check({tag, "_a1"}, wa[first+1], 32'h0000_0004);
    check({tag, "_d1"}, wd[first+1], 32'h0010_8133);
  endtask

  initial begin
    // Payload byte XOR: 93^00^50^00^33^81^10^00 = 0x61.
    good = '{8'hA5, 8'h02, 8'h00,
             8'h93, 8'h00, 8'h50, 8'h00,
             8'h33, 8'h81, 8'h10, 8'h00,
             8'h61};
    bad = good;
    bad[11] = 8'h62;

    repeat (2) @(negedge clk);
    #1;
    chk_reset("por");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    frame(good, 0);
    check("good_nwr", wa.size(), 2);
    chk_words("good", 0);
    chk_status("good_st", 3'b110);
    frame(good, 0);
    check("done_ign_nwr", wa.size(), 2);
    chk_status("done_ign_st", 3'b110);

    do_reset("rst1");
    clear_log();
    frame(bad, 0);
    chk_status("bad_st", 3'b001);
    check("bad_nwr", wa.size(), 2);
    frame(good, 0);
    check("reload_nwr", wa.size(), 4);
    chk_words("reload", 2);
    chk_status("reload_st", 3'b110);

    do_reset("rst2");
    clear_log();
    send(8'hA5, 0);
    send(8'h01, 0);
    send(8'h01, 0);
    idle(2);
    chk_status("big_st", 3'b001);
    send(8'h11, 0);
    send(8'h22, 0);
    send(8'h33, 0);
    send(8'h44, 0);
    idle(3);
    check("big_nwr", wa.size(), 0);
    chk_status("big_st2", 3'b001);

    do_reset("rst3");
    clear_log();
    frame('{8'hA5, 8'h00, 8'h00, 8'h00}, 0);
    chk_status("zero_st", 3'b110);
    check("zero_nwr", wa.size(), 0);
    frame(good, 0);
    check("zero_ign_nwr", wa.size(), 0);
    chk_status("zero_ign_st", 3'b110);

    do_reset("rst4");
    clear_log();
    for (int i = 0; i < 9; i++) send(good[i], 0);
    do_reset("abort");
    idle(3);
    check("abort_nwr", wa.size(), 1);
    chk_status("abort_st", 3'b000);
    clear_log();
    frame(good, 0);
    check("fresh_nwr", wa.size(), 2);
    chk_words("fresh", 0);
    chk_status("fresh_st", 3'b110);

    do_reset("rst5");
    clear_log();
    send(8'h00, 1);
    send(8'hFF, 1);
    frame(good, 2);
    check("gap_nwr", wa.size(), 2);
    chk_words("gap", 0);
    chk_status("gap_st", 3'b110);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
